// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says pattern generator: LFSR taps by width,
// sequencer states and the default game sizing used by the game controller.
package simon_pkg;

  localparam int COLOURS_DEF = 4;
  localparam int MAX_LEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Maximal-length Galois taps, right-aligned in a 32-bit word.
  function automatic logic [31:0] taps_for(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Width-parametrised Galois LFSR with synchronous load and step; exposes only
// the low OUT_W bits that the sequencer turns into a colour index.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter int W     = 32,
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [W-1:0]     load_val_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] low_o
);

  localparam logic [31:0]  TAPS32 = taps_for(W);
  localparam logic [W-1:0] TAPS   = TAPS32[W-1:0];

  logic [W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (step_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign low_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/simon_seq_gen.sv
// Simon Says colour sequence generator: free-running counter captured as seed,
// replayable LFSR pass emitted one colour per valid/ready handshake.
module simon_seq_gen
  import simon_pkg::*;
#(
  parameter int SEED_W  = 32,
  parameter int COLOURS = COLOURS_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  localparam int COL_W  = $clog2(COLOURS),
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              replay,
  input  logic [LEN_W-1:0]  round_len,
  output logic              col_valid,
  input  logic              col_ready,
  output logic [COL_W-1:0]  colour,
  output logic [LEN_W-1:0]  step,
  output logic              col_last,
  output logic [SEED_W-1:0] seed,
  output logic              busy
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] r);
    if (r == '0) begin
      return LEN_W'(1);
    end else if (int'(r) > MAX_LEN) begin
      return LEN_W'(MAX_LEN);
    end else begin
      return r;
    end
  endfunction

  state_e              state_q, state_d;
  logic [SEED_W-1:0]   cnt_q, cnt_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic                seed_ok_q, seed_ok_d;
  logic [LEN_W-1:0]    step_q, step_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                lfsr_load, lfsr_adv;
  logic [SEED_W-1:0]   lfsr_val;
  logic [SEED_W-1:0]   new_seed;
  logic                at_last;

  // An all-zero seed would lock the LFSR, so a zero count seeds with 1.
  assign new_seed = (cnt_q == '0) ? SEED_W'(1) : cnt_q;
  assign at_last  = (step_q == len_q - LEN_W'(1));

  always_comb begin
    cnt_d     = cnt_q + SEED_W'(1);
    seed_d    = seed_q;
    seed_ok_d = seed_ok_q;
    step_d    = step_q;
    len_d     = len_q;
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    lfsr_val  = seed_q;
    // A start event in any state restarts the pass; a handshake in that cycle is dropped.
    if (capture) begin
      seed_d    = new_seed;
      seed_ok_d = 1'b1;
      lfsr_val  = new_seed;
      lfsr_load = 1'b1;
      step_d    = '0;
      len_d     = clamp_len(round_len);
      state_d   = EMIT;
    end else if (replay && seed_ok_q) begin
      lfsr_load = 1'b1;
      step_d    = '0;
      len_d     = clamp_len(round_len);
      state_d   = EMIT;
    end else if (state_q == EMIT && col_ready) begin
      if (at_last) begin
        state_d = DONE;
      end else begin
        lfsr_adv = 1'b1;
        step_d   = step_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      seed_q    <= '0;
      seed_ok_q <= 1'b0;
      step_q    <= '0;
      len_q     <= '0;
      state_q   <= IDLE;
    end else begin
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      seed_ok_q <= seed_ok_d;
      step_q    <= step_d;
      len_q     <= len_d;
      state_q   <= state_d;
    end
  end

  simon_lfsr #(
    .W     (SEED_W),
    .OUT_W (COL_W)
  ) u_lfsr (
    .clk        (clk),
    .rst        (reset),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_val),
    .step_i     (lfsr_adv),
    .low_o      (colour)
  );

  assign col_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign col_last  = (state_q == EMIT) && at_last;
  assign step      = step_q;
  assign seed      = seed_q;

endmodule
